// File: rtl/u_mem_responder_pkg.sv
// -----------------------------------------------------------------------------
// u_mem_resp_pkg
// Shared types and helpers for the local-memory responder.
//   t_resp_state  : responder FSM states
//   data_n_bytes(): byte-lane count for a given data width (rounded up)
// -----------------------------------------------------------------------------
package u_mem_resp_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WR_BURST = 2'd1,
        RD_BURST = 2'd2
    } t_resp_state;

    // Number of byte lanes covering a bus of data_width bits; a partial top
    // byte still gets its own enable.
    function automatic int data_n_bytes(input int data_width);
        return (data_width + 7) / 8;
    endfunction

endpackage

// File: rtl/u_mem_bram.sv
// -----------------------------------------------------------------------------
// u_mem_bram
// Simple dual-port RAM: one byte-enabled write port, one read port with a
// single registered read stage. A read and a write to the same word in the
// same cycle returns the newly written bytes (write-first).
// Ports:
//   clk        clock
//   reset      synchronous active-high; clears only the read output register
//   i_wr_en    write strobe
//   i_wr_addr  write word address
//   i_wr_data  write data
//   i_wr_be    per-byte write enable
//   i_rd_en    read strobe; o_rd_data updates on the next clock
//   i_rd_addr  read word address
//   o_rd_data  registered read data
// -----------------------------------------------------------------------------
module u_mem_bram
    import u_mem_resp_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10,
    parameter int DATA_WIDTH = 512
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                i_wr_en,
    input  logic [DEPTH_LOG2-1:0]               i_wr_addr,
    input  logic [DATA_WIDTH-1:0]               i_wr_data,
    input  logic [data_n_bytes(DATA_WIDTH)-1:0] i_wr_be,
    input  logic                                i_rd_en,
    input  logic [DEPTH_LOG2-1:0]               i_rd_addr,
    output logic [DATA_WIDTH-1:0]               o_rd_data
);

    localparam int N_BYTES   = data_n_bytes(DATA_WIDTH);
    localparam int PAD_WIDTH = N_BYTES * 8;
    localparam int DEPTH     = 1 << DEPTH_LOG2;

    // Storage is padded to whole bytes so every lane is a clean 8-bit slice.
    logic [PAD_WIDTH-1:0]  r_mem [DEPTH];
    logic [PAD_WIDTH-1:0]  w_wr_data_pad;
    logic [PAD_WIDTH-1:0]  w_rd_word;
    logic [DATA_WIDTH-1:0] r_rd_data;

    assign w_wr_data_pad = PAD_WIDTH'(i_wr_data);

    // NOTE: the array itself has no reset; clearing every word would need a
    // sequencer and would stop the storage mapping onto block RAM.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            for (int b = 0; b < N_BYTES; b++) begin
                if (i_wr_be[b]) begin
                    r_mem[i_wr_addr][b*8 +: 8] <= w_wr_data_pad[b*8 +: 8];
                end
            end
        end
    end

    // Write-first merge: lanes being written this cycle override stored data.
    always_comb begin
        w_rd_word = r_mem[i_rd_addr];
        if (i_wr_en && (i_wr_addr == i_rd_addr)) begin
            for (int b = 0; b < N_BYTES; b++) begin
                if (i_wr_be[b]) begin
                    w_rd_word[b*8 +: 8] = w_wr_data_pad[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= w_rd_word[DATA_WIDTH-1:0];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/u_mem_responder.sv
// -----------------------------------------------------------------------------
// u_mem_responder
// Avalon-MM burst responder (to_afu side of local memory) backed by an
// on-chip byte-enabled RAM. Writes land one beat per cycle with gaps allowed;
// a read burst of N beats returns data on the N cycles starting two cycles
// after acceptance, with waitrequest held while the burst is being issued.
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   waitrequest    high while a read burst is being issued
//   readdata       read beat data (registered)
//   readdatavalid  readdata valid this cycle (registered)
//   burstcount     beats in burst, sampled on the first beat
//   writedata      write beat data
//   address        word address, sampled on the first beat
//   write, read    command / beat strobes
//   byteenable     per-byte write enable
//   err_sticky     protocol violation seen since reset
// -----------------------------------------------------------------------------
module u_mem_responder
    import u_mem_resp_pkg::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 512,
    parameter int BURST_CNT_WIDTH = 7,
    parameter int DEPTH_LOG2      = 10
) (
    input  logic                                clk,
    input  logic                                reset,
    output logic                                waitrequest,
    output logic [DATA_WIDTH-1:0]               readdata,
    output logic                                readdatavalid,
    input  logic [BURST_CNT_WIDTH-1:0]          burstcount,
    input  logic [DATA_WIDTH-1:0]               writedata,
    input  logic [ADDR_WIDTH-1:0]               address,
    input  logic                                write,
    input  logic                                read,
    input  logic [data_n_bytes(DATA_WIDTH)-1:0] byteenable,
    output logic                                err_sticky
);

    t_resp_state                r_state;
    logic [DEPTH_LOG2-1:0]      r_addr;       // next word to write or read
    logic [BURST_CNT_WIDTH-1:0] r_remaining;  // beats still to write or issue
    logic                       r_rvalid;
    logic                       r_err;

    logic [DEPTH_LOG2-1:0]      w_cmd_addr;
    logic [BURST_CNT_WIDTH-1:0] w_bc_eff;
    logic                       w_bc_zero;
    logic                       w_wr_en;
    logic [DEPTH_LOG2-1:0]      w_wr_addr;
    logic                       w_rd_en;
    logic                       w_unused_addr_hi;

    // Upper address bits are deliberately not decoded; addressing wraps.
    assign w_cmd_addr       = address[DEPTH_LOG2-1:0];
    assign w_unused_addr_hi = ^address[ADDR_WIDTH-1:DEPTH_LOG2];

    // A zero burstcount is serviced as a single beat (and flagged).
    assign w_bc_zero = (burstcount == '0);
    assign w_bc_eff  = w_bc_zero ? BURST_CNT_WIDTH'(1) : burstcount;

    // RAM port control. Reads and writes are never active together, so the
    // FSM state alone decides which port is used this cycle.
    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_addr = r_addr;
        w_rd_en   = 1'b0;
        if (!reset) begin
            unique case (r_state)
                IDLE: begin
                    w_wr_en   = write;
                    w_wr_addr = w_cmd_addr;
                end
                WR_BURST: w_wr_en = write;
                RD_BURST: w_rd_en = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_remaining <= '0;
            r_rvalid    <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            // Each issue cycle's data emerges from the RAM one cycle later.
            r_rvalid <= (r_state == RD_BURST);
            unique case (r_state)
                IDLE: begin
                    if (write) begin
                        // Beat 0 is written this cycle; a colliding read is dropped.
                        r_addr      <= w_cmd_addr + DEPTH_LOG2'(1);
                        r_remaining <= w_bc_eff - BURST_CNT_WIDTH'(1);
                        r_state     <= (w_bc_eff == BURST_CNT_WIDTH'(1)) ? IDLE : WR_BURST;
                        if (read || w_bc_zero) begin
                            r_err <= 1'b1;
                        end
                    end else if (read) begin
                        r_addr      <= w_cmd_addr;
                        r_remaining <= w_bc_eff;
                        r_state     <= RD_BURST;
                        if (w_bc_zero) begin
                            r_err <= 1'b1;
                        end
                    end
                end
                WR_BURST: begin
                    if (read) begin
                        r_err <= 1'b1;
                    end
                    if (write) begin
                        r_addr      <= r_addr + DEPTH_LOG2'(1);
                        r_remaining <= r_remaining - BURST_CNT_WIDTH'(1);
                        if (r_remaining == BURST_CNT_WIDTH'(1)) begin
                            r_state <= IDLE;
                        end
                    end
                end
                RD_BURST: begin
                    r_addr      <= r_addr + DEPTH_LOG2'(1);
                    r_remaining <= r_remaining - BURST_CNT_WIDTH'(1);
                    if (r_remaining == BURST_CNT_WIDTH'(1)) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    u_mem_bram #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_bram (
        .clk       (clk),
        .reset     (reset),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (w_wr_addr),
        .i_wr_data (writedata),
        .i_wr_be   (byteenable),
        .i_rd_en   (w_rd_en),
        .i_rd_addr (r_addr),
        .o_rd_data (readdata)
    );

    assign waitrequest   = (r_state == RD_BURST);
    assign readdatavalid = r_rvalid;
    assign err_sticky    = r_err;

endmodule
